// File: rtl/mc_controller.sv
// Multicycle ARM-subset control unit: Moore FSM plus combinational decoders and a condition/flag unit.
// One state per clk edge; B=3, STR=4, DP=4, LDR=5 and illegal Op=2 cycles including FETCH.
module mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUControl
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] flags;
  logic       condex, condex_r;
  logic       nextpc, regw, memw, branch, aluop, nowrite, pcs;
  logic [1:0] flagw;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = FETCH;
    nextpc    = 1'b0;
    regw      = 1'b0;
    memw      = 1'b0;
    branch    = 1'b0;
    aluop     = 1'b0;
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    case (state)
      FETCH: begin
        state_nxt = DECODE;
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = 1'b1;
        nextpc    = 1'b1;
      end
      DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        case (Op)
          2'b00:   state_nxt = Funct[5] ? EXECUTEI : EXECUTER;
          2'b01:   state_nxt = MEMADR;
          2'b10:   state_nxt = BRANCH;
          default: state_nxt = FETCH;
        endcase
      end
      MEMADR: begin
        ALUSrcB   = 2'b01;
        state_nxt = Funct[0] ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        AdrSrc    = 1'b1;
        state_nxt = MEMWB;
      end
      MEMWRITE: begin
        AdrSrc = 1'b1;
        memw   = 1'b1;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        regw      = 1'b1;
      end
      EXECUTER: begin
        aluop     = 1'b1;
        state_nxt = ALUWB;
      end
      EXECUTEI: begin
        ALUSrcB   = 2'b01;
        aluop     = 1'b1;
        state_nxt = ALUWB;
      end
      ALUWB: regw = 1'b1;
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        branch    = 1'b1;
      end
      default: state_nxt = FETCH;
    endcase
  end

  always_comb begin
    ALUControl = 2'b00;
    flagw      = 2'b00;
    if (aluop) begin
      case (Funct[4:1])
        4'b0100: begin ALUControl = 2'b00; flagw = {2{Funct[0]}};   end
        4'b0010: begin ALUControl = 2'b01; flagw = {2{Funct[0]}};   end
        4'b0000: begin ALUControl = 2'b10; flagw = {Funct[0], 1'b0}; end
        4'b1100: begin ALUControl = 2'b11; flagw = {Funct[0], 1'b0}; end
        4'b1010: begin ALUControl = 2'b01; flagw = 2'b11;            end
        default: ;
      endcase
    end
  end

  // NoWrite must still be visible in ALUWB, where ALUOp is already 0.
  assign nowrite = (Op == 2'b00) && (Funct[4:1] == 4'b1010);

  always_comb begin
    case (Op)
      2'b01:   ImmSrc = 2'b01;
      2'b10:   ImmSrc = 2'b10;
      default: ImmSrc = 2'b00;
    endcase
    RegSrc = {(Op == 2'b01) & ~Funct[0], Op == 2'b10};
  end

  always_comb begin
    case (Cond)
      4'b0000: condex = flags[2];
      4'b0001: condex = ~flags[2];
      4'b0010: condex = flags[1];
      4'b0011: condex = ~flags[1];
      4'b0100: condex = flags[3];
      4'b0101: condex = ~flags[3];
      4'b0110: condex = flags[0];
      4'b0111: condex = ~flags[0];
      4'b1000: condex = flags[1] & ~flags[2];
      4'b1001: condex = ~flags[1] | flags[2];
      4'b1010: condex = flags[3] == flags[0];
      4'b1011: condex = flags[3] != flags[0];
      4'b1100: condex = ~flags[2] & (flags[3] == flags[0]);
      4'b1101: condex = flags[2] | (flags[3] != flags[0]);
      4'b1110: condex = 1'b1;
      default: condex = 1'b0;
    endcase
  end

  // CondEx is frozen leaving DECODE so an S-suffixed op cannot re-judge itself in ALUWB.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags    <= 4'b0000;
      condex_r <= 1'b0;
    end else begin
      if (state == DECODE) condex_r <= condex;
      if (state == EXECUTER || state == EXECUTEI) begin
        if (flagw[1] & condex_r) flags[3:2] <= ALUFlags[3:2];
        if (flagw[0] & condex_r) flags[1:0] <= ALUFlags[1:0];
      end
    end
  end

  assign pcs      = ((Rd == 4'b1111) & regw) | branch;
  assign PCWrite  = nextpc | (pcs & condex_r);
  assign RegWrite = regw & condex_r & ~nowrite;
  assign MemWrite = memw & condex_r;

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 The module SHALL have exactly one clock and one reset: clk is the only clock, and reset is asynchronous and active-high.
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: reset  input  1  asynchronous, active-high; forces state FETCH and clears flags.
REQ-004 Port: Cond  input  4  instruction bits [31:28].
REQ-005 Port: Op  input  2  instruction bits [27:26]: 00 DP, 01 Mem, 10 B, 11 illegal.
REQ-006 Port: Funct  input  6  instruction bits [25:20]: [5] = I, [4:1] = cmd, [0] = S or L.
REQ-007 Port: Rd  input  4  instruction bits [15:12].
REQ-008 Port: ALUFlags  input  4  {N,Z,C,V} from the ALU in the current cycle.
REQ-009 Port: PCWrite, RegWrite, MemWrite, IRWrite, AdrSrc  output  1 each  datapath enables and selects.
REQ-010 Port: RegSrc, ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl  output  2 each  datapath selects.

Function
REQ-011 The FSM SHALL have the states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB and BRANCH, and SHALL advance one state per clk edge.
REQ-012 Transitions SHALL be as follows:
- FETCH goes to DECODE.
- DECODE goes to MEMADR (Op=01), EXECUTER (Op=00, I=0), EXECUTEI (Op=00, I=1), BRANCH (Op=10), or FETCH (Op=11).
- MEMADR goes to MEMREAD (L=1) or MEMWRITE (L=0).
- MEMREAD goes to MEMWB.
- EXECUTER and EXECUTEI go to ALUWB.
- MEMWB, MEMWRITE, ALUWB and BRANCH go to FETCH.
REQ-013 Latencies in cycles, including FETCH, SHALL be: B = 3, STR = 4, DP = 4, LDR = 5, illegal Op = 2.
REQ-014 Moore controls SHALL take these values; any select not listed is 0:
- FETCH: AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, IRWrite=1, NextPC=1.
- DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
- MEMADR and EXECUTEI: ALUSrcA=00, ALUSrcB=01.
- EXECUTER: ALUSrcA=00, ALUSrcB=00.
- MEMREAD and MEMWRITE: AdrSrc=1, ResultSrc=00; MEMWRITE also sets MemW=1.
- MEMWB: ResultSrc=01, RegW=1.
- ALUWB: ResultSrc=00, RegW=1.
- BRANCH: ALUSrcA=00, ALUSrcB=01, ResultSrc=10, Branch=1.
- ALUOp=1 only in EXECUTER and EXECUTEI.
REQ-015 ImmSrc and RegSrc SHALL be decoded combinationally from Op and Funct and held in every state:
- ImmSrc: 00 for DP, 01 for Mem, 10 for B.
- RegSrc[1]=1 only for STR; RegSrc[0]=1 only for B.
REQ-016 When ALUOp=0, ALUControl SHALL be 00 (add) and FlagW SHALL be 00.
REQ-017 When ALUOp=1, ALUControl SHALL be ADD(0100)→00, SUB(0010)→01, AND(0000)→10, ORR(1100)→11, CMP(1010)→01.
REQ-018 When ALUOp=1, FlagW SHALL be:
- ADD/SUB with S=1: 11.
- AND/ORR with S=1: 10.
- CMP: 11 regardless of S.
- otherwise: 00.
REQ-019 NoWrite SHALL be 1 only for CMP; any other cmd SHALL give ALUControl=00, FlagW=00, NoWrite=0.
REQ-020 The flag register {N,Z,C,V} SHALL update on the clk edge ending an EXECUTE state:
- N,Z load ALUFlags[3:2] when FlagW[1] & CondEx.
- C,V load ALUFlags[1:0] when FlagW[0] & CondEx.
- Otherwise the flags hold.
REQ-021 CondEx SHALL be evaluated combinationally from the registered flags, with standard ARM semantics for Cond 0000–1110 (EQ…LE, AL=1); Cond=1111 SHALL give CondEx=0.
REQ-022 PCS SHALL equal ((Rd==1111) & RegW) | Branch.
REQ-023 The gated outputs SHALL be:
- PCWrite = NextPC | (PCS & CondEx).
- RegWrite = RegW & CondEx & ~NoWrite.
- MemWrite = MemW & CondEx.
REQ-024 A failed condition SHALL still traverse the full state path (fixed latency), with every architectural write suppressed.
REQ-025 Flags written in EXECUTE SHALL NOT affect CondEx of the same instruction, because the same flags are sampled in ALUWB after the update; CondEx SHALL therefore be computed once per instruction and registered on entry to the EXECUTE, MEMADR and BRANCH states.
REQ-026 IRWrite and NextPC SHALL be unconditional, i.e. not gated by CondEx.

Reset
REQ-027 While reset is high, the state SHALL be FETCH and the flags SHALL be 0000.
REQ-028 While reset is high, outputs SHALL be IRWrite=1, PCWrite=1, AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, and RegWrite=MemWrite=0.
REQ-029 A reset asserted in any state SHALL take effect immediately without a clock, and the first rising edge after deassertion SHALL move FETCH→DECODE.

Verification
REQ-030 The bench SHALL cover ADD R1 (Cond=1110, Op=00, Funct=001000, Rd=0001):
- Stimulus: the ADD above.
- Required response: states FETCH, DECODE, EXECUTER, ALUWB; RegWrite=1 only in ALUWB; PCWrite=1 only in FETCH; ALUControl=00.
REQ-031 The bench SHALL cover LDR and STR (Op=01, Funct[0]=1 and then 0):
- Stimulus: LDR, then STR.
- Required response: LDR takes 5 cycles with RegWrite only in MEMWB and ResultSrc=01 there.
- Required response: STR takes 4 cycles with MemWrite only in MEMWRITE and RegSrc=10.
REQ-032 The bench SHALL cover a CMP followed by conditional adds:
- Stimulus: CMP (Funct=010101) with ALUFlags=0100, then ADDEQ (Cond=0000), then ADDNE (Cond=0001).
- Required response: Z=1 after CMP; ADDEQ asserts RegWrite; ADDNE keeps RegWrite=0 for all 4 cycles; CMP itself never asserts RegWrite.
REQ-033 The bench SHALL cover B (Op=10, Cond=1110):
- Stimulus: the branch above.
- Required response: 3 cycles; PCWrite=1 in BRANCH; ImmSrc=10.
- Stimulus: the same branch with Cond=1111.
- Required response: PCWrite=0 in BRANCH.
REQ-034 The bench SHALL cover data-processing writes to PC (Rd=1111):
- Stimulus: ADD with Rd=1111.
- Required response: PCWrite=1 in ALUWB.
- Stimulus: ADD with Rd=1111 and Cond failing.
- Required response: PCWrite=0 in ALUWB.
REQ-035 The bench SHALL cover illegal Op and reset mid-operation:
- Stimulus: Op=11.
- Required response: DECODE→FETCH with no write.
- Stimulus: reset pulsed mid-cycle while in MEMREAD.
- Required response: state becomes FETCH asynchronously; flags become 0000; MemWrite and RegWrite stay 0.
